// File: rtl/matbi_tick_pkg.sv
// Shared definitions for the multi-channel tick generator: channel states, modes, default width.
// Optional build macro used by the top level: MATBI_TICK_CASCADE_EN.
package matbi_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tick_state_t;

    localparam logic PERIODIC = 1'b0;
    localparam logic ONESHOT  = 1'b1;

    localparam int unsigned DEF_COUNT_BIT = 30;

endpackage

// File: rtl/matbi_tick_ch.sv
// One tick channel: IDLE/RUN/DONE FSM, wrap counter and shadow divisor.
// Counting advances only on cycles where i_cnt_en is high; control inputs act every cycle.
module matbi_tick_ch
    import matbi_tick_pkg::*;
#(
    parameter int unsigned P_COUNT_BIT = DEF_COUNT_BIT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [P_COUNT_BIT-1:0] i_div,
    input  logic                   i_mode,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_hold,
    input  logic                   i_cnt_en,
    output logic                   o_tick,
    output logic                   o_busy,
    output logic                   o_cfg_err
);

    localparam logic [P_COUNT_BIT-1:0] CNT_ZERO = {P_COUNT_BIT{1'b0}};
    localparam logic [P_COUNT_BIT-1:0] CNT_ONE  = {{(P_COUNT_BIT-1){1'b0}}, 1'b1};

    tick_state_t            state_r;
    tick_state_t            state_s;
    logic [P_COUNT_BIT-1:0] cnt_r;
    logic [P_COUNT_BIT-1:0] cnt_s;
    logic [P_COUNT_BIT-1:0] div_r;
    logic [P_COUNT_BIT-1:0] div_s;
    logic [P_COUNT_BIT-1:0] div_m1_s;
    logic                   tick_r;
    logic                   tick_s;
    logic                   busy_r;
    logic                   busy_s;
    logic                   err_r;
    logic                   err_s;
    logic                   wrap_s;
    logic                   div_ok_s;

    assign div_m1_s = div_r - CNT_ONE;
    assign wrap_s   = (cnt_r == div_m1_s);
    assign div_ok_s = (i_div != CNT_ZERO);

    // State, counter, divisor and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            div_r   <= CNT_ZERO;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            div_r   <= div_s;
            tick_r  <= tick_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

    // Next-state logic with priority stop > start > hold > count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        div_s   = div_r;
        tick_s  = 1'b0;
        err_s   = err_r;
        if (i_stop) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
        end else if (i_start && div_ok_s) begin
            state_s = RUN;
            cnt_s   = CNT_ZERO;
            div_s   = i_div;
            err_s   = 1'b0;
        end else begin
            // A rejected start only flags the error; the channel carries on as if no start came.
            if (i_start) begin
                err_s = 1'b1;
            end else begin
                err_s = err_r;
            end
            case (state_r)
                RUN: begin
                    if (i_hold || !i_cnt_en) begin
                        cnt_s = cnt_r;
                    end else if (wrap_s) begin
                        cnt_s  = CNT_ZERO;
                        tick_s = 1'b1;
                        if (i_mode == ONESHOT) begin
                            state_s = DONE;
                        end else if (div_ok_s) begin
                            div_s = i_div;
                        end else begin
                            div_s = div_r;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                IDLE, DONE: begin
                    cnt_s = cnt_r;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
        busy_s = (state_s == RUN);
    end

    assign o_tick    = tick_r;
    assign o_busy    = busy_r;
    assign o_cfg_err = err_r;

endmodule

// File: rtl/matbi_multi_tick_gen.sv
// Multi-channel tick generator: P_CH independent divide-by-N tick channels.
// Define MATBI_TICK_CASCADE_EN to chain channel k's count enable to the tick of channel k-1.
module matbi_multi_tick_gen
    import matbi_tick_pkg::*;
#(
    parameter int unsigned P_CH        = 4,
    parameter int unsigned P_COUNT_BIT = DEF_COUNT_BIT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [P_CH*P_COUNT_BIT-1:0] i_div,
    input  logic [P_CH-1:0]             i_mode,
    input  logic [P_CH-1:0]             i_start,
    input  logic [P_CH-1:0]             i_stop,
    input  logic [P_CH-1:0]             i_hold,
    output logic [P_CH-1:0]             o_tick,
    output logic [P_CH-1:0]             o_busy,
    output logic [P_CH-1:0]             o_cfg_err
);

    logic [P_CH-1:0] tick_s;
    logic [P_CH-1:0] cnt_en_s;

    genvar k;
    generate
        for (k = 0; k < P_CH; k++) begin : g_ch
`ifdef MATBI_TICK_CASCADE_EN
            // Channel 0 is the root of the chain and always counts clk.
            if (k == 0) begin : g_root
                assign cnt_en_s[k] = 1'b1;
            end else begin : g_casc
                assign cnt_en_s[k] = tick_s[k-1];
            end
`else
            assign cnt_en_s[k] = 1'b1;
`endif
            matbi_tick_ch #(
                .P_COUNT_BIT (P_COUNT_BIT)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_div     (i_div[k*P_COUNT_BIT +: P_COUNT_BIT]),
                .i_mode    (i_mode[k]),
                .i_start   (i_start[k]),
                .i_stop    (i_stop[k]),
                .i_hold    (i_hold[k]),
                .i_cnt_en  (cnt_en_s[k]),
                .o_tick    (tick_s[k]),
                .o_busy    (o_busy[k]),
                .o_cfg_err (o_cfg_err[k])
            );
        end
    endgenerate

    assign o_tick = tick_s;

endmodule

// File: tb/tb_matbi_multi_tick_gen.sv
// Directed self-checking bench for matbi_multi_tick_gen (4 channels, 30-bit divisors).
module tb_matbi_multi_tick_gen;

    localparam int NCH = 4;
    localparam int W   = 30;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic [NCH*W-1:0]   i_div = '0;
    logic [NCH-1:0]     i_mode = '0;
    logic [NCH-1:0]     i_start = '0;
    logic [NCH-1:0]     i_stop = '0;
    logic [NCH-1:0]     i_hold = '0;
    logic [NCH-1:0]     o_tick;
    logic [NCH-1:0]     o_busy;
    logic [NCH-1:0]     o_cfg_err;

    int errors = 0;
    int checks = 0;

    matbi_multi_tick_gen #(.P_CH(NCH), .P_COUNT_BIT(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_div     (i_div),
        .i_mode    (i_mode),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_hold    (i_hold),
        .o_tick    (o_tick),
        .o_busy    (o_busy),
        .o_cfg_err (o_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int val);
        i_div[ch*W +: W] = val[W-1:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_tick", o_tick, 4'b0000);
        chk("rst_busy", o_busy, 4'b0000);
        chk("rst_err", o_cfg_err, 4'b0000);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", o_busy, 4'b0000);

        // Periodic ch0, D=5
        set_div(0, 5);
        i_start[0] = 1'b1;
        step();
        i_start[0] = 1'b0;
        chk("p5_busy_start", o_busy, 4'b0001);
        chk("p5_tick_start", o_tick, 4'b0000);
        for (int n = 1; n <= 16; n++) begin
            step();
            chk($sformatf("p5_tick n=%0d", n), o_tick, (n % 5 == 0) ? 4'b0001 : 4'b0000);
        end
        i_stop[0] = 1'b1;
        step();
        i_stop[0] = 1'b0;
        chk("p5_stop_busy", o_busy, 4'b0000);
        chk("p5_stop_tick", o_tick, 4'b0000);

        // One-shot ch1, D=3, then restart from DONE
        set_div(1, 3);
        i_mode[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            i_start[1] = 1'b1;
            step();
            i_start[1] = 1'b0;
            chk($sformatf("os_busy_start r=%0d", r), o_busy, 4'b0010);
            for (int n = 1; n <= 5; n++) begin
                step();
                chk($sformatf("os_tick r=%0d n=%0d", r, n), o_tick, (n == 3) ? 4'b0010 : 4'b0000);
                chk($sformatf("os_busy r=%0d n=%0d", r, n), o_busy, (n < 3) ? 4'b0010 : 4'b0000);
            end
        end
        i_mode[1] = 1'b0;

        // Periodic ch2, D=4; i_div=0 at first wrap keeps 4, then 2 takes effect at the next wrap
        set_div(2, 4);
        i_start[2] = 1'b1;
        step();
        i_start[2] = 1'b0;
        set_div(2, 0);
        for (int n = 1; n <= 12; n++) begin
            step();
            e = (n == 4 || n == 8 || n == 10 || n == 12) ? 4'b0100 : 4'b0000;
            chk($sformatf("div_upd n=%0d", n), o_tick, e);
            if (n == 6) set_div(2, 2);
        end
        i_stop[2] = 1'b1;
        step();
        i_stop[2] = 1'b0;

        // Start with D=0 on ch3 is rejected; D=1 then clears the flag and ticks every cycle
        set_div(3, 0);
        i_start[3] = 1'b1;
        step();
        i_start[3] = 1'b0;
        chk("d0_err", o_cfg_err, 4'b1000);
        chk("d0_busy", o_busy, 4'b0000);
        step();
        chk("d0_err_sticky", o_cfg_err, 4'b1000);
        set_div(3, 1);
        i_start[3] = 1'b1;
        step();
        i_start[3] = 1'b0;
        chk("d1_err_clr", o_cfg_err, 4'b0000);
        chk("d1_busy", o_busy, 4'b1000);
        chk("d1_tick_start", o_tick, 4'b0000);
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("d1_tick n=%0d", n), o_tick, 4'b1000);
        end
        i_stop[3] = 1'b1;
        step();
        i_stop[3] = 1'b0;
        chk("d1_stop_tick", o_tick, 4'b0000);

        // Start and stop together: stop wins
        set_div(0, 2);
        i_start[0] = 1'b1;
        i_stop[0]  = 1'b1;
        step();
        i_start[0] = 1'b0;
        i_stop[0]  = 1'b0;
        chk("ss_busy", o_busy, 4'b0000);
        step();
        step();
        chk("ss_tick", o_tick, 4'b0000);

        // ch0 D=3: hold over the wrap at 6 delays it to 9; start at the wrap at 15 restarts
        set_div(0, 3);
        i_start[0] = 1'b1;
        step();
        i_start[0] = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            step();
            e = (n == 3 || n == 9 || n == 12 || n == 18) ? 4'b0001 : 4'b0000;
            chk($sformatf("hold_rst n=%0d", n), o_tick, e);
            chk($sformatf("hold_busy n=%0d", n), o_busy, 4'b0001);
            i_hold[0]  = (n >= 5 && n <= 7);
            i_start[0] = (n == 14);
        end
        i_stop[0] = 1'b1;
        step();
        i_stop[0] = 1'b0;

        // ch0 D=2 with ch1 D=3, started together
        set_div(0, 2);
        set_div(1, 3);
        i_start[1:0] = 2'b11;
        step();
        i_start[1:0] = 2'b00;
        for (int n = 1; n <= 15; n++) begin
            step();
            e = 4'b0000;
            e[0] = (n % 2 == 0);
`ifdef MATBI_TICK_CASCADE_EN
            e[1] = (n > 1) && (n % 6 == 1);
`else
            e[1] = (n % 3 == 0);
`endif
            chk($sformatf("casc n=%0d", n), o_tick, e);
        end
        // Stop coinciding with ch0's wrap at 16 suppresses the tick
        i_stop[0] = 1'b1;
        step();
        i_stop[0] = 1'b0;
        chk("stop_wrap_tick", o_tick, 4'b0000);
        chk("stop_wrap_busy", o_busy, 4'b0010);

        // Asynchronous reset mid-count
        set_div(3, 0);
        i_start[3] = 1'b1;
        step();
        i_start[3] = 1'b0;
        chk("pre_rst_err", o_cfg_err, 4'b1000);
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", o_busy, 4'b0000);
        chk("async_rst_err", o_cfg_err, 4'b0000);
        chk("async_rst_tick", o_tick, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matbi_multi_tick_gen.md
# matbi_multi_tick_gen

Parametrised multi-channel tick generator, the successor to the single one-second tick source. Each channel divides `clk` by its own divisor and emits single-cycle ticks, in periodic or one-shot mode, with start/stop/hold control and glitch-free divisor updates. It sits between the clock domain and the watch counters (sec/min/hour, alarm, stopwatch), which consume `o_tick` as count enables.

## Interface
- `P_CH`, 4: number of independent channels.
- `P_COUNT_BIT`, 30: divisor and counter width per channel.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_div`  in  P_CH*P_COUNT_BIT  per-channel divisor; channel k uses bits [k*P_COUNT_BIT +: P_COUNT_BIT].
- `i_mode`  in  P_CH  per channel: 0 = periodic, 1 = one-shot.
- `i_start`  in  P_CH  per-channel start/restart pulse.
- `i_stop`  in  P_CH  per-channel stop pulse.
- `i_hold`  in  P_CH  per-channel level; freezes the counter while high.
- `o_tick`  out  P_CH  registered single-cycle tick.
- `o_busy`  out  P_CH  channel is in RUN.
- `o_cfg_err`  out  P_CH  sticky flag: the last start was rejected because the divisor was 0.

## Operation
- Each channel has three states: IDLE, RUN, DONE. It also holds `r_div` (the latched divisor) and `r_cnt`.
- Reset value of all outputs is 0. Reset puts every channel in IDLE with `r_cnt`=0 and `r_div`=0.
- Priority per channel, per cycle: stop > start > hold > count.
- Stop, from any state: go to IDLE, `r_cnt`←0, no tick.
- Start with `i_div`≠0, from any state:
  - `r_div`←`i_div`, `r_cnt`←0, go to RUN, `o_cfg_err`←0.
  - No tick is issued in the start cycle.
- Start with `i_div`=0: ignored, state unchanged, `o_cfg_err`←1.
- Hold in RUN: `r_cnt` and state freeze; `o_tick`=0.
- Count in RUN, on each enabled cycle:
  - If `r_cnt == r_div-1` (compared at P_COUNT_BIT width): `r_cnt`←0 and `o_tick`←1.
    - Periodic mode: `r_div`←`i_div` if `i_div`≠0, else keep the old value. Divisor changes take effect only at this wrap boundary.
    - One-shot mode: go to DONE.
  - Otherwise `r_cnt`←`r_cnt`+1 and `o_tick`←0.
- `i_mode` is sampled every cycle. Changing it mid-RUN takes effect at the next wrap.
- Divisor 1 produces a tick on every enabled cycle.
- DONE behaves as IDLE except for its state encoding. `o_busy`=0 in both.

## Timing
- Start is sampled at edge E0. For a clk-counting channel with divisor D, the first `o_tick` is high in the cycle after edge E0+D. Ticks then repeat every D cycles.
- `o_tick` is exactly one cycle wide. There are never two consecutive ticks unless D=1.
- Start during RUN restarts the phase. It suppresses the tick even if a wrap coincided.
- Stop coinciding with a wrap: no tick.
- Hold coinciding with a wrap: no tick. The wrap occurs on the first un-held enabled cycle.
- `o_busy` goes high the cycle after the start edge. It goes low the cycle after the stop edge, or after the final one-shot tick edge, coincident with that tick.
- Deasserting `reset_n` takes effect asynchronously. Release must be synchronised externally.

## Configuration
- `MATBI_TICK_CASCADE_EN` defined: for k≥1, channel k's count enable is `o_tick[k-1]`. Channel k then counts ticks of k-1, which builds sec→min→hour chains. Channel 0 always counts `clk`.
- Cascade cycle accounting: the cascaded tick lags by one clk cycle per stage. Channel k's start/stop/hold still act every clk cycle.
- `MATBI_TICK_CASCADE_EN` undefined: every channel counts `clk` cycles independently, and `o_tick[k-1]` has no effect on channel k.

## Structure
- Shared package `matbi_tick_pkg` contains:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: PERIODIC=1'b0, ONESHOT=1'b1.
  - Default `P_COUNT_BIT`.
- Sub-module `matbi_tick_ch` implements one channel: FSM, counter, and shadow divisor, with a count-enable input.
- The top level instantiates `matbi_tick_ch` P_CH times with a generate loop. It also slices `i_div` and applies the cascade wiring.

## Test plan
- Periodic, ch0, D=5, start at cycle 10: ticks at cycles 15, 20, 25…; `o_busy`=1 from cycle 11.
- One-shot, D=3: exactly one tick at start+3. `o_busy` falls with that tick, the state goes to DONE, and a restart ticks again at +3.
- Periodic D=4 running; change `i_div` to 2 mid-period: the current period stays 4, then the period becomes 2. `i_div`=0 at a wrap keeps period 4.
- Collisions:
  - start with D=0 → `o_cfg_err`=1 and `o_busy` stays 0.
  - start and stop in the same cycle → IDLE.
  - hold for 3 cycles at a wrap → the tick is delayed by 3 cycles.
  - `reset_n` low mid-count → all outputs 0 immediately.
- With `MATBI_TICK_CASCADE_EN`: ch0 D=2, ch1 D=3 → ch1 ticks once per 3 ch0 ticks, one clk after every third ch0 tick. Without the macro, ch1 ticks every 3 clk.
